// File: rtl/line_dispatch_if.sv
// Command handshake between the primitive decoder (master) and the line
// dispatcher (slave). cmd_data packs {x0[9:0], y0[8:0], x1[9:0], y1[8:0]}.
interface line_dispatch_if;
  logic        cmd_valid;
  logic [37:0] cmd_data;
  logic        cmd_ready;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/line_dispatch.sv
// Line-engine command scheduler: buffers line commands in a small FIFO, issues
// them one at a time, pauses the engine on framebuffer contention, aborts overlong lines.
module line_dispatch #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1048576
) (
  input  logic                          clk,
  input  logic                          n_rst,
  line_dispatch_if.slave                cmd,
  input  logic                          flush,
  input  logic                          fb_busy,
  output logic [37:0]                   eng_positions,
  output logic                          eng_start,
  output logic                          eng_stop,
  output logic                          eng_clr_n,
  input  logic                          eng_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   lines_done,
  output logic                          err,
  input  logic                          err_clr
);

  localparam int DATA_W = 38;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WD_W   = $clog2(TIMEOUT) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, RUN, ABORT} state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  eng_positions_q, eng_positions_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [15:0]        lines_done_q, lines_done_d;
  logic               err_q, err_d;
  logic               settle_q, settle_d;
  logic               push, pop;

  assign cmd.cmd_ready  = (count_q < CNT_FULL) & ~flush;
  assign push           = cmd.cmd_valid & cmd.cmd_ready;
  assign busy           = (state_q != IDLE) | (count_q != '0);
  assign fifo_count     = count_q;
  assign lines_done     = lines_done_q;
  assign err            = err_q;
  assign eng_positions  = eng_positions_q;

  always_comb begin
    state_d         = state_q;
    eng_positions_d = eng_positions_q;
    wd_d            = wd_q;
    lines_done_d    = lines_done_q;
    err_d           = err_q;
    settle_d        = 1'b0;
    pop             = 1'b0;
    eng_start       = 1'b0;
    eng_stop        = 1'b0;
    eng_clr_n       = 1'b1;

    if (err_clr) err_d = 1'b0;

    case (state_q)
      // settle_q holds off dispatch for one cycle after a line ends so the
      // engine always sees a two-cycle gap before its next start pulse.
      IDLE: begin
        if ((count_q != '0) && !flush && !settle_q) begin
          eng_positions_d = mem_q[rd_ptr_q];
          pop             = 1'b1;
          state_d         = START;
        end
      end
      START: begin
        eng_start = 1'b1;
        wd_d      = '0;
        state_d   = RUN;
      end
      RUN: begin
        eng_stop = fb_busy;
        if (eng_done) begin
          lines_done_d = lines_done_q + 16'd1;
          settle_d     = 1'b1;
          state_d      = IDLE;
        end else if (!fb_busy) begin
          if (wd_q == WD_LAST) state_d = ABORT;
          else                 wd_d    = wd_q + 1'b1;
        end
      end
      ABORT: begin
        eng_clr_n = 1'b0;
        err_d     = 1'b1;
        settle_d  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= cmd.cmd_data;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      eng_positions_q <= '0;
      wd_q            <= '0;
      lines_done_q    <= '0;
      err_q           <= 1'b0;
      settle_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      eng_positions_q <= eng_positions_d;
      wd_q            <= wd_d;
      lines_done_q    <= lines_done_d;
      err_q           <= err_d;
      settle_q        <= settle_d;
    end
  end

endmodule
